// File: rtl/xilinx_phy10g_qpll_reset_seq.sv
// QPLL reset/lock sequencer: one independent FSM per GTXE2_COMMON bank with power-up hold,
// reset pulse, lock timeout with bounded retries and stability qualification. Optional macro: QPLL_LOCKLOSS_CNT_EN.
module xilinx_phy10g_qpll_reset_seq #(
    parameter int NUM_QUADS          = 1,
    parameter int PWRUP_CYCLES       = 50000,
    parameter int RESET_CYCLES       = 16,
    parameter int LOCK_TIMEOUT       = 100000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_QUADS-1:0]   restart_i,
    input  logic [NUM_QUADS-1:0]   qplllock_i,
    output logic [NUM_QUADS-1:0]   qpllreset_o,
    output logic [NUM_QUADS-1:0]   ready_o,
    output logic [NUM_QUADS-1:0]   fail_o,
    output logic                   all_ready_o
`ifdef QPLL_LOCKLOSS_CNT_EN
    ,
    output logic [8*NUM_QUADS-1:0] lockloss_cnt_o
`endif
);

    localparam int MAX_PR  = (PWRUP_CYCLES > RESET_CYCLES) ? PWRUP_CYCLES : RESET_CYCLES;
    localparam int MAX_TS  = (LOCK_TIMEOUT > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_PR > MAX_TS) ? MAX_PR : MAX_TS;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    // Counters run downwards from (duration - 1); a state is left when they reach zero.
    localparam logic [CNT_W-1:0] C_PWRUP   = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_RESET   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_STABLE  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] C_RTY_MAX = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_READY,
        ST_FAIL
    } state_t;

    logic [NUM_QUADS-1:0] r_lock_meta;
    logic [NUM_QUADS-1:0] r_lock_sync;
    logic                 r_all_ready;

    // QPLLLOCK is asynchronous to clk_i; this is the only crossing in the block.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock_meta <= '0;
            r_lock_sync <= '0;
        end else begin
            r_lock_meta <= qplllock_i;
            r_lock_sync <= r_lock_meta;
        end
    end

    for (genvar q = 0; q < NUM_QUADS; q++) begin : g_quad
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [RTY_W-1:0] r_rty;
        logic [RTY_W-1:0] w_rty_nxt;
        logic             r_qpllreset;
        logic             r_ready;
        logic             r_fail;
        logic             w_lock_s;

        assign w_lock_s = r_lock_sync[q];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_state     <= ST_PWRUP;
                r_cnt       <= C_PWRUP;
                r_rty       <= '0;
                r_qpllreset <= 1'b1;
                r_ready     <= 1'b0;
                r_fail      <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_cnt       <= w_cnt_nxt;
                r_rty       <= w_rty_nxt;
                r_qpllreset <= (w_state_nxt == ST_PWRUP) || (w_state_nxt == ST_RESET);
                r_ready     <= (w_state_nxt == ST_READY);
                r_fail      <= (w_state_nxt == ST_FAIL);
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_rty_nxt   = r_rty;
            // A held restart keeps reloading the reset counter, so the pulse length counts from release.
            if (restart_i[q]) begin
                w_state_nxt = ST_RESET;
                w_cnt_nxt   = C_RESET;
                w_rty_nxt   = '0;
            end else begin
                case (r_state)
                    ST_PWRUP: begin
                        if (r_cnt == '0) begin
                            w_state_nxt = ST_RESET;
                            w_cnt_nxt   = C_RESET;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                    ST_RESET: begin
                        if (r_cnt == '0) begin
                            w_state_nxt = ST_WAIT_LOCK;
                            w_cnt_nxt   = C_TIMEOUT;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (w_lock_s) begin
                            w_state_nxt = ST_STABLE;
                            w_cnt_nxt   = C_STABLE;
                        end else if (r_cnt == '0) begin
                            if (r_rty < C_RTY_MAX) begin
                                w_state_nxt = ST_RESET;
                                w_cnt_nxt   = C_RESET;
                                w_rty_nxt   = r_rty + RTY_W'(1);
                            end else begin
                                w_state_nxt = ST_FAIL;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                    ST_STABLE: begin
                        // A dropout here is not a new attempt: the retry budget is kept.
                        if (!w_lock_s) begin
                            w_state_nxt = ST_WAIT_LOCK;
                            w_cnt_nxt   = C_TIMEOUT;
                        end else if (r_cnt == '0) begin
                            w_state_nxt = ST_READY;
                            w_rty_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                    ST_READY: begin
                        if (!w_lock_s) begin
                            w_state_nxt = ST_RESET;
                            w_cnt_nxt   = C_RESET;
                            w_rty_nxt   = '0;
                        end
                    end
                    ST_FAIL: begin
                        w_state_nxt = ST_FAIL;
                    end
                    default: begin
                        w_state_nxt = ST_PWRUP;
                        w_cnt_nxt   = C_PWRUP;
                        w_rty_nxt   = '0;
                    end
                endcase
            end
        end

        assign qpllreset_o[q] = r_qpllreset;
        assign ready_o[q]     = r_ready;
        assign fail_o[q]      = r_fail;

`ifdef QPLL_LOCKLOSS_CNT_EN
        logic [7:0] r_llc;
        logic       w_lockloss;

        // Only genuine lock loss counts; a restart issued in the same cycle takes precedence.
        assign w_lockloss = (r_state == ST_READY) && !w_lock_s && !restart_i[q];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_llc <= 8'd0;
            end else if (w_lockloss && (r_llc != 8'hFF)) begin
                r_llc <= r_llc + 8'd1;
            end
        end

        assign lockloss_cnt_o[8*q +: 8] = r_llc;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_all_ready <= 1'b0;
        end else begin
            r_all_ready <= &ready_o;
        end
    end

    assign all_ready_o = r_all_ready;

endmodule
